// File: rtl/alu_result_collector_if.sv
// alu_result_collector_if: execution-unit result input, downstream handshake and status bundle
interface alu_result_collector_if #(
  parameter int OUT_DATA_WIDTH = 16,
  parameter int TAG_WIDTH      = 4,
  parameter int DEPTH          = 4,
  parameter int CNT_WIDTH      = 8
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [OUT_DATA_WIDTH-1:0] alu_out;
  logic                      out_valid;
  logic [TAG_WIDTH-1:0]      alu_tag;
  logic [OUT_DATA_WIDTH-1:0] res_data;
  logic [TAG_WIDTH-1:0]      res_tag;
  logic                      res_valid;
  logic                      res_ready;
  logic [CW-1:0]             count;
  logic                      overflow;
  logic [CNT_WIDTH-1:0]      drop_cnt;
  logic                      clr_ovf;
  modport master (
    output alu_out, out_valid, alu_tag, res_ready, clr_ovf,
    input  res_data, res_tag, res_valid, count, overflow, drop_cnt
  );
  modport slave (
    input  alu_out, out_valid, alu_tag, res_ready, clr_ovf,
    output res_data, res_tag, res_valid, count, overflow, drop_cnt
  );
endinterface

// File: rtl/alu_result_collector.sv
// alu_result_collector: FWFT FIFO capturing flagged ALU results with sticky overflow and saturating drop count
module alu_result_collector #(
  parameter int OUT_DATA_WIDTH = 16,
  parameter int TAG_WIDTH      = 4,
  parameter int DEPTH          = 4,
  parameter int CNT_WIDTH      = 8
) (
  input  logic clk,
  input  logic rst_n,
  alu_result_collector_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [OUT_DATA_WIDTH-1:0] data_q [DEPTH];
  logic [TAG_WIDTH-1:0]      tag_q  [DEPTH];
  logic [PW-1:0]             wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]      drop_q, drop_d;
  logic                      push, pop, drop;
  // Handshake decode and next-state; a full FIFO still accepts when the head leaves the same cycle
  always_comb begin
    pop     = (count_q != '0) & bus.res_ready;
    push    = bus.out_valid & ((count_q != FULL) | pop);
    drop    = bus.out_valid & (count_q == FULL) & ~pop;
    wr_d    = push ? wr_q + PW'(1) : wr_q;
    rd_d    = pop ? rd_q + PW'(1) : rd_q;
    count_d = count_q + CW'(push) - CW'(pop);
    ovf_d   = bus.clr_ovf ? 1'b0 : ovf_q | drop;
    drop_d  = bus.clr_ovf ? '0 : (drop & ~&drop_q) ? drop_q + CNT_WIDTH'(1) : drop_q;
  end
  // Pointer, occupancy and overflow state; reset empties the queue immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end
  // Storage needs no reset; contents are only visible while occupancy covers them
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_q] <= bus.alu_out;
      tag_q[wr_q]  <= bus.alu_tag;
    end
  end
  // Head presented straight from storage, forced to zero when empty
  always_comb begin
    bus.res_valid = count_q != '0;
    bus.res_data  = bus.res_valid ? data_q[rd_q] : '0;
    bus.res_tag   = bus.res_valid ? tag_q[rd_q] : '0;
    bus.count     = count_q;
    bus.overflow  = ovf_q;
    bus.drop_cnt  = drop_q;
  end
endmodule

// File: tb/tb_alu_result_collector.sv
// tb_alu_result_collector: directed self-checking bench for alu_result_collector
module tb_alu_result_collector;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  alu_result_collector_if #(.OUT_DATA_WIDTH(16), .TAG_WIDTH(4), .DEPTH(4), .CNT_WIDTH(8)) bif ();
  alu_result_collector #(.OUT_DATA_WIDTH(16), .TAG_WIDTH(4), .DEPTH(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] t);
    bif.out_valid = v;
    bif.alu_out   = d;
    bif.alu_tag   = t;
  endtask
  initial begin
    drive(1'b0, 16'h0, 4'h0);
    bif.res_ready = 1'b0;
    bif.clr_ovf   = 1'b0;
    #12;
    chk("rst_valid", 32'(bif.res_valid), 0);
    chk("rst_count", 32'(bif.count), 0);
    chk("rst_data", 32'(bif.res_data), 0);
    chk("rst_tag", 32'(bif.res_tag), 0);
    chk("rst_ovf", 32'(bif.overflow), 0);
    chk("rst_drop", 32'(bif.drop_cnt), 0);
    rst_n = 1'b1;
    tick();
    drive(1'b1, 16'h00A5, 4'h2);
    tick();
    drive(1'b0, 16'hFFFF, 4'hF);
    chk("t1_valid", 32'(bif.res_valid), 1);
    chk("t1_data", 32'(bif.res_data), 32'h00A5);
    chk("t1_tag", 32'(bif.res_tag), 2);
    chk("t1_count", 32'(bif.count), 1);
    tick();
    chk("t1_novalid_nopush", 32'(bif.count), 1);
    bif.res_ready = 1'b1;
    tick();
    bif.res_ready = 1'b0;
    chk("t1_pop_count", 32'(bif.count), 0);
    chk("t1_pop_data", 32'(bif.res_data), 0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'(i), 4'(i));
      tick();
    end
    chk("t2_full_count", 32'(bif.count), 4);
    chk("t2_full_ovf", 32'(bif.overflow), 0);
    drive(1'b1, 16'h0005, 4'h5);
    tick();
    drive(1'b0, 16'h0, 4'h0);
    chk("t2_drop_count", 32'(bif.count), 4);
    chk("t2_drop_ovf", 32'(bif.overflow), 1);
    chk("t2_drop_cnt", 32'(bif.drop_cnt), 1);
    chk("t2_head_stable", 32'(bif.res_data), 1);
    bif.res_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t2_drain_data", 32'(bif.res_data), 32'(i));
      chk("t2_drain_tag", 32'(bif.res_tag), 32'(i));
      tick();
    end
    bif.res_ready = 1'b0;
    chk("t2_empty_valid", 32'(bif.res_valid), 0);
    chk("t2_empty_count", 32'(bif.count), 0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'(i), 4'(i));
      tick();
    end
    drive(1'b1, 16'h0006, 4'h6);
    bif.res_ready = 1'b1;
    tick();
    drive(1'b0, 16'h0, 4'h0);
    chk("t3_count", 32'(bif.count), 4);
    chk("t3_drop_cnt", 32'(bif.drop_cnt), 1);
    for (int i = 2; i <= 5; i++) begin
      chk("t3_drain_data", 32'(bif.res_data), (i == 5) ? 32'h6 : 32'(i));
      tick();
    end
    chk("t3_empty", 32'(bif.count), 0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 16'h0100 + 16'(i), 4'(i));
      tick();
      chk("t4_head", 32'(bif.res_data), 32'h0100 + 32'(i));
      chk("t4_count", 32'(bif.count), 1);
    end
    drive(1'b0, 16'h0, 4'h0);
    tick();
    chk("t4_end_count", 32'(bif.count), 0);
    chk("t4_no_drops", 32'(bif.drop_cnt), 1);
    bif.res_ready = 1'b0;
    bif.clr_ovf = 1'b1;
    tick();
    bif.clr_ovf = 1'b0;
    chk("t5_clr_ovf", 32'(bif.overflow), 0);
    chk("t5_clr_drop", 32'(bif.drop_cnt), 0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'h0040 + 16'(i), 4'h4);
      tick();
    end
    repeat (254) tick();
    chk("t5_drop_254", 32'(bif.drop_cnt), 32'hFE);
    tick();
    chk("t5_drop_255", 32'(bif.drop_cnt), 32'hFF);
    repeat (45) tick();
    chk("t5_drop_sat", 32'(bif.drop_cnt), 32'hFF);
    chk("t5_ovf", 32'(bif.overflow), 1);
    chk("t5_count", 32'(bif.count), 4);
    bif.clr_ovf = 1'b1;
    tick();
    bif.clr_ovf = 1'b0;
    drive(1'b0, 16'h0, 4'h0);
    chk("t5_clr_prio_ovf", 32'(bif.overflow), 0);
    chk("t5_clr_prio_drop", 32'(bif.drop_cnt), 0);
    chk("t5_head_kept", 32'(bif.res_data), 32'h0041);
    bif.res_ready = 1'b1;
    repeat (4) tick();
    bif.res_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 16'h0030 + 16'(i), 4'h3);
      tick();
    end
    drive(1'b0, 16'h0, 4'h0);
    chk("t6_count3", 32'(bif.count), 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(bif.res_valid), 0);
    chk("t6_async_count", 32'(bif.count), 0);
    chk("t6_async_data", 32'(bif.res_data), 0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("t6_still_empty", 32'(bif.res_valid), 0);
    drive(1'b1, 16'h0077, 4'h7);
    tick();
    drive(1'b0, 16'h0, 4'h0);
    chk("t6_repush_valid", 32'(bif.res_valid), 1);
    chk("t6_repush_data", 32'(bif.res_data), 32'h0077);
    chk("t6_repush_tag", 32'(bif.res_tag), 7);
    chk("t6_repush_count", 32'(bif.count), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
